// File: rtl/hmlf6_topk_select.sv
// Sequential top-k selector for the 6-element HMLF DAC: ranks element states from the
// maximum down, one pick per cycle, and returns the chosen elements as a select mask.
module hmlf6_topk_select #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a5,
   input  logic [W-1:0] a4,
   input  logic [W-1:0] a3,
   input  logic [W-1:0] a2,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] a0,
   input  logic [2:0]   k,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [5:0]   sel,
   output logic [W-1:0] kth_val
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic signed [W-1:0] vals [6];
   logic [2:0]          rem;
   logic signed [W-1:0] best_val;
   logic [2:0]          best_idx;
   logic                found;
   logic                last_pick;

   function automatic logic [2:0] clamp_k(input logic [2:0] kin);
      return (kin > 3'd6) ? 3'd6 : kin;
   endfunction

   assign in_ready  = (state == IDLE);
   assign last_pick = (rem <= 3'd1);

   // Strict '>' while scanning upward keeps the lowest index on ties.
   always_comb begin
      best_val = '0;
      best_idx = '0;
      found    = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (!sel[i] && (!found || (vals[i] > best_val))) begin
            found    = 1'b1;
            best_val = vals[i];
            best_idx = 3'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid) state_nxt = (clamp_k(k) == 3'd0) ? DONE : RUN;
         end
         RUN: begin
            if (last_pick) state_nxt = DONE;
         end
         DONE: begin
            if (out_valid && out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // out_valid rises with the final pick, or one edge after capture when k=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 6; i++) vals[i] <= '0;
         rem       <= '0;
         sel       <= '0;
         kth_val   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               if (in_valid) begin
                  vals[0] <= $signed(a0);
                  vals[1] <= $signed(a1);
                  vals[2] <= $signed(a2);
                  vals[3] <= $signed(a3);
                  vals[4] <= $signed(a4);
                  vals[5] <= $signed(a5);
                  rem     <= clamp_k(k);
                  sel     <= '0;
                  kth_val <= '0;
               end
            end
            RUN: begin
               if (found) begin
                  sel[best_idx] <= 1'b1;
                  kth_val       <= best_val;
               end
               rem <= rem - 3'd1;
               if (last_pick) out_valid <= 1'b1;
            end
            DONE: begin
               out_valid <= !(out_valid && out_ready);
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_hmlf6_topk_select.sv
// Directed bench for hmlf6_topk_select: ranking, ties, clamp, k=0, extremes,
// handshake back-pressure and asynchronous reset in the middle of a run.
module tb_hmlf6_topk_select;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] a5, a4, a3, a2, a1, a0;
   logic [2:0] k;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] sel;
   logic [5:0] kth_val;

   int errors = 0;
   int checks = 0;

   hmlf6_topk_select #(.W(6)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a5       (a5),
      .a4       (a4),
      .a3       (a3),
      .a2       (a2),
      .a1       (a1),
      .a0       (a0),
      .k        (k),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sel      (sel),
      .kth_val  (kth_val)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input int v5, input int v4, input int v3,
                          input int v2, input int v1, input int v0);
      a5 = 6'(v5); a4 = 6'(v4); a3 = 6'(v3);
      a2 = 6'(v2); a1 = 6'(v1); a0 = 6'(v0);
   endtask

   task automatic scramble();
      set_vec($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
   endtask

   // Called right after the accepting edge; counts edges until out_valid, then releases.
   task automatic wait_done(input string tag, input int exp_lat,
                            input int exp_sel, input int exp_kth);
      int lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_sel"}, int'(sel), exp_sel);
      check({tag, "_kth"}, int'($signed(kth_val)), exp_kth);
      check({tag, "_busy"}, int'(in_ready), 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_drop"}, int'(out_valid), 0);
      check({tag, "_idle"}, int'(in_ready), 1);
   endtask

   task automatic run_vec(input string tag,
                          input int v5, input int v4, input int v3,
                          input int v2, input int v1, input int v0,
                          input int kk, input int exp_sel, input int exp_kth);
      int n;
      n = (kk > 6) ? 6 : kk;
      set_vec(v5, v4, v3, v2, v1, v0);
      k = 3'(kk);
      in_valid = 1'b1;
      check({tag, "_rdy"}, int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      scramble();
      k = 3'($urandom);
      wait_done(tag, (n == 0) ? 1 : n, exp_sel, exp_kth);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; k = 3'd5;
      scramble();
      #12;
      check("rst_valid", int'(out_valid), 0);
      check("rst_sel", int'(sel), 0);
      check("rst_kth", int'(kth_val), 0);
      check("rst_ready", int'(in_ready), 1);
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      tick();
      check("post_rst_ready", int'(in_ready), 1);
      check("post_rst_valid", int'(out_valid), 0);

      run_vec("basic", 3, -2, 7, 0, 5, -8, 3, 'b101010, 3);
      run_vec("ties", -1, -1, -1, -1, -1, -1, 2, 'b000011, -1);
      run_vec("clamp", 3, -2, 7, 0, 5, -8, 7, 'b111111, -8);
      run_vec("k0", 3, -2, 7, 0, 5, -8, 0, 'b000000, 0);
      run_vec("ext", 0, 0, 0, 0, 31, -32, 1, 'b000010, 31);
      run_vec("six", 1, 2, 3, 4, 5, 6, 6, 'b111111, 1);

      // Back-pressure and non-capture while busy.
      set_vec(10, -3, 10, 4, -20, 0);
      k = 3'd2;
      in_valid = 1'b1;
      check("hs_rdy", int'(in_ready), 1);
      tick();
      set_vec(3, -2, 7, 0, 5, -8);
      k = 3'd3;
      tick();
      check("hs_run_ready", int'(in_ready), 0);
      check("hs_run_valid", int'(out_valid), 0);
      tick();
      check("hs_done_valid", int'(out_valid), 1);
      check("hs_done_sel", int'(sel), 'b101000);
      check("hs_done_kth", int'($signed(kth_val)), 10);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hs_hold_sel", int'(sel), 'b101000);
         check("hs_hold_ready", int'(in_ready), 0);
         check("hs_hold_valid", int'(out_valid), 1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hs_rel_valid", int'(out_valid), 0);
      check("hs_rel_ready", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      scramble();
      wait_done("b2b", 3, 'b101010, 3);

      // Asynchronous reset during the second RUN cycle.
      set_vec(3, -2, 7, 0, 5, -8);
      k = 3'd5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("mid_progress_sel", int'(sel), 'b001000);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_sel", int'(sel), 0);
      check("mid_rst_kth", int'(kth_val), 0);
      check("mid_rst_ready", int'(in_ready), 1);
      #2 rst_n = 1'b1;
      tick();
      check("mid_after_ready", int'(in_ready), 1);
      check("mid_after_valid", int'(out_valid), 0);
      run_vec("after", 3, -2, 7, 0, 5, -8, 3, 'b101010, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hmlf6_topk_select.md
Name: hmlf6_topk_select

Overview:
- Sequential top-k element selector for the 6-element HMLF mismatch-shaping DAC path.
- Accepts the six signed element states and a requested element count k.
- Iteratively picks the k largest states and returns a one-hot-per-element select vector for the unit-element array.
- Mirrors the MIN6 normalization stage: that stage finds the minimum; this block consumes the states and ranks from the maximum down.

Parameters:
W, 6, state word width (signed two's complement); element count is fixed at 6.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input vector and k are valid.
in_ready  output  1  block can accept a new vector; high only in IDLE.
a5..a0  input  W each  signed element states.
k  input  3  number of elements to select; values 7 clamp to 6.
out_valid  output  1  sel and kth_val are valid.
out_ready  input  1  downstream consumes the result.
sel  output  6  bit i=1 means element i is selected.
kth_val  output  W  signed state of the last element selected (the k-th largest); 0 when k=0.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, out_valid=0, sel=0, kth_val=0, internal value registers=0, remaining=0, so in_ready=1 once out of reset.
- Reset asserted mid-operation aborts the operation immediately; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge, capture a5..a0 and rem=min(k,6), clear sel and kth_val.
  - If rem=0, go to DONE; else go to RUN.
- RUN (in_ready=0):
  - Each cycle, find the maximum signed value among elements with sel bit 0.
  - Set that sel bit, load its value into kth_val, and decrement rem.
  - When rem reaches 0 on this edge, go to DONE.
  - Ties: the lowest index wins (a0 before a5).
  - Comparisons are full W-bit signed. No arithmetic is performed on the values, so there is no overflow case.
- DONE:
  - out_valid=1; sel and kth_val stay stable.
  - On out_ready, go to IDLE and drop out_valid on that edge.
  - out_ready while not in DONE is ignored.
- Latency: if a vector is accepted at edge t, out_valid is high from edge t+k (k=0: from edge t+1, the next registered edge after capture). Throughput is one vector per k+2 cycles minimum, with no overlap.
- Input changes after capture are ignored.
- in_valid while in_ready=0 is not accepted. The sender must hold the vector until it sees in_ready=1 with in_valid=1 at an edge.
- sel always has exactly min(k,6) bits set.
- All outputs are registered, except in_ready, which decodes directly from state.

Test Plan:
- Reset then idle: rst_n low with random inputs -> out_valid=0, sel=0, kth_val=0, in_ready=1. Release reset -> still idle.
- Basic rank: a5..a0 = 3,-2,7,0,5,-8 with k=3 -> out_valid 3 cycles after accept. sel=6'b101010, kth_val=3.
- Ties and clamp:
  - All elements = -1 with k=2 -> sel=6'b000011, kth_val=-1.
  - k=7 with distinct values -> sel=6'b111111, kth_val equals the minimum.
- k=0 and extremes:
  - k=0 -> out_valid at the next edge, sel=0, kth_val=0.
  - a0=-32, a1=31, others 0, k=1 -> sel=6'b000010, kth_val=31.
- Handshake:
  - Hold out_ready=0 for 5 cycles -> sel stable and in_ready=0.
  - A new in_valid during RUN/DONE is not captured.
  - Assert out_ready -> IDLE next cycle; back-to-back vectors are processed correctly.
- Reset mid-RUN: k=5, assert rst_n=0 during the 2nd RUN cycle -> outputs go to reset values asynchronously. The next vector completes normally.
